// File: rtl/sram_mem_controller_if.sv
// Request/response bus between the MEM pipeline stage and the
// multi-cycle SRAM data-memory controller.
interface sram_mem_controller_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   // MEM stage side: issues the request, consumes the result.
   modport master (
      output wr_en, rd_en, address, write_data,
      input  read_data, ready
   );

   // Controller side: accepts the request, returns data and ready.
   modport slave (
      input  wr_en, rd_en, address, write_data,
      output read_data, ready
   );
endinterface : sram_mem_controller_if

// File: rtl/sram_mem_controller.sv
// Multi-cycle data-memory controller. Turns one 32-bit load/store from the
// MEM stage into two 16-bit accesses (low half, then high half) on an
// external asynchronous SRAM, holding ready low while the access is in flight.
module sram_mem_controller #(
   parameter int unsigned ADDR_BASE   = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_mem_controller_if.slave bus,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [15:0]          sram_dq_out,
   input  logic [15:0]          sram_dq_in,
   output logic                 sram_dq_oe,
   output logic                 sram_we_n
);

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } state_t;

   // Wait counter only needs to reach WAIT_CYCLES-1.
   localparam int unsigned   CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     wait_cnt;
   logic [SRAM_AW-2:0]   word_q;     // latched 32-bit word index (SRAM pair base >> 1)
   logic [31:0]          data_q;     // latched store data
   logic                 is_wr_q;    // latched op: 1 = store, 0 = load
   logic [31:0]          read_data_q;
   logic                 req;
   logic                 last_cycle;
   logic                 hi_phase;
   logic [31:0]          offset;
   logic                 unused_offset_bits;

   assign req        = bus.wr_en | bus.rd_en;
   assign last_cycle = (wait_cnt == LAST_CNT);
   assign hi_phase   = (state == HI);

   // Rebase the byte address; wraps below ADDR_BASE, then the word index is
   // truncated so that {word, half} fits in SRAM_AW bits.
   assign offset             = bus.address - 32'(ADDR_BASE);
   assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   // Next-state logic for the access sequencer.
   always_comb begin
      // NOTE: assign a default before the case so no path leaves state_nxt unassigned (latch).
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = LO;
         LO:      if (last_cycle) state_nxt = HI;
         HI:      if (last_cycle) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register, wait counter and request latch.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         word_q   <= '0;
         data_q   <= '0;
         is_wr_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req) begin
            word_q  <= offset[SRAM_AW:2];
            data_q  <= bus.write_data;
            is_wr_q <= bus.wr_en;       // store wins when both are requested
         end
         if (state == LO || state == HI) begin
            wait_cnt <= last_cycle ? '0 : wait_cnt + 1'b1;
         end
      end
   end

   // Capture each returned half on the last cycle of its read phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data_q <= '0;
      end else if (!is_wr_q && last_cycle) begin
         if (state == LO) read_data_q[15:0]  <= sram_dq_in;
         if (state == HI) read_data_q[31:16] <= sram_dq_in;
      end
   end

   // SRAM bus decode: idle values outside LO/HI, write drive only for stores.
   always_comb begin
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      if (state == LO || state == HI) begin
         sram_addr = {word_q, hi_phase};
         if (is_wr_q) begin
            sram_dq_oe  = 1'b1;
            sram_we_n   = 1'b0;
            sram_dq_out = hi_phase ? data_q[31:16] : data_q[15:0];
         end
      end
   end

   assign bus.read_data = read_data_q;
   // A fresh request drops ready in the same cycle so the pipeline freezes at once.
   assign bus.ready     = ((state == IDLE) && !req) || (state == DONE);

endmodule : sram_mem_controller
